// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS control unit.
// Opcodes, state encodings, datapath select codes and the control bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_ADDI  = 6'd8;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADR   = 4'd3;
  localparam logic [3:0] S_MEMRD    = 4'd4;
  localparam logic [3:0] S_MEMWB    = 4'd5;
  localparam logic [3:0] S_MEMWR    = 4'd6;
  localparam logic [3:0] S_RTYPE_EX = 4'd7;
  localparam logic [3:0] S_RTYPE_WB = 4'd8;
  localparam logic [3:0] S_BR_EX    = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;
  localparam logic [3:0] S_ADDI_EX  = 4'd11;
  localparam logic [3:0] S_ADDI_WB  = 4'd12;
  localparam logic [3:0] S_ERROR    = 4'd15;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_TGT = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic       branch_sel;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       instr_done;
  } ctrl_t;

  function automatic logic [3:0] decode_next(
    input logic [5:0] op,
    input logic       bne_en
  );
    logic [3:0] nxt;
    nxt = S_ERROR;
    unique case (1'b1)
      (op == OP_RTYPE):            nxt = S_RTYPE_EX;
      (op == OP_LW):               nxt = S_MEMADR;
      (op == OP_SW):               nxt = S_MEMADR;
      (op == OP_BEQ):              nxt = S_BR_EX;
      (op == OP_BNE) && bne_en:    nxt = S_BR_EX;
      (op == OP_J):                nxt = S_JUMP;
      (op == OP_ADDI):             nxt = S_ADDI_EX;
      default:                     nxt = S_ERROR;
    endcase
    return nxt;
  endfunction

  function automatic logic is_wait_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles in a memory-wait state and flags a timeout.
// A limit of 0 disables the timeout; the counter then simply wraps.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  localparam int W =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LIM = W'(MEM_TIMEOUT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (active && !mem_ready) begin
      cnt <= cnt + W'(1);
    end
  end

  // ready in the limit cycle wins: timeout only asserts while not ready
  assign timeout = (MEM_TIMEOUT != 0) && active
                && !mem_ready && (cnt == LIM);

endmodule

// File: rtl/control_multi.sv
// Multicycle MIPS main control FSM with memory-wait timeout.
// Outputs decode from the registered state; FETCH/MEMWR also use mem_ready.
module control_multi
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter bit BNE_EN      = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       Branch_Sel,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic       instr_done,
  output logic       err,
  output logic [3:0] state_o
);

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       timeout;
  ctrl_t      c;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (state_nxt != state),
    .active    (is_wait_state(state)),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     state_nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    state_nxt = S_DECODE;
        else if (timeout) state_nxt = S_ERROR;
      end
      S_DECODE:   state_nxt = decode_next(opcode, BNE_EN);
      S_MEMADR:   state_nxt = (opcode == OP_LW) ? S_MEMRD
                                                : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)    state_nxt = S_MEMWB;
        else if (timeout) state_nxt = S_ERROR;
      end
      S_MEMWR: begin
        if (mem_ready)    state_nxt = S_FETCH;
        else if (timeout) state_nxt = S_ERROR;
      end
      S_MEMWB:    state_nxt = S_FETCH;
      S_RTYPE_EX: state_nxt = S_RTYPE_WB;
      S_RTYPE_WB: state_nxt = S_FETCH;
      S_BR_EX:    state_nxt = S_FETCH;
      S_JUMP:     state_nxt = S_FETCH;
      S_ADDI_EX:  state_nxt = S_ADDI_WB;
      S_ADDI_WB:  state_nxt = S_FETCH;
      S_ERROR:    state_nxt = S_ERROR;
      default:    state_nxt = S_ERROR;
    endcase
  end

  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      S_DECODE: c.alu_src_b = SRCB_IMMSH;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write  = 1'b1;
        c.i_or_d     = 1'b1;
        c.instr_done = mem_ready;
      end
      S_RTYPE_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        c.reg_dst    = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BR_EX: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_TGT;
        c.branch_sel    = (opcode == OP_BNE);
        c.instr_done    = 1'b1;
      end
      S_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCSRC_JMP;
        c.instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
  end

  assign PCWrite     = c.pc_write;
  assign PCWriteCond = c.pc_write_cond;
  assign IorD        = c.i_or_d;
  assign MemRead     = c.mem_read;
  assign MemWrite    = c.mem_write;
  assign IRWrite     = c.ir_write;
  assign MemtoReg    = c.mem_to_reg;
  assign ALUSrcA     = c.alu_src_a;
  assign RegWrite    = c.reg_write;
  assign RegDst      = c.reg_dst;
  assign Branch_Sel  = c.branch_sel;
  assign PCSource    = c.pc_source;
  assign ALUOp       = c.alu_op;
  assign ALUSrcB     = c.alu_src_b;
  assign instr_done  = c.instr_done;
  assign err         = (state == S_ERROR);
  assign state_o     = state;

endmodule

// File: doc/control_multi.md
CONTROL_MULTI -- requirements
Module: control_multi

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum cycles to wait for mem_ready in a memory state; 0 disables the timeout.
REQ-002 SHALL have parameter BNE_EN, default 1: 1 decodes opcode 5 (BNE); 0 treats opcode 5 as illegal.
REQ-003 SHALL use one clock, clk; reset is asynchronous and active-low, reset_n.
REQ-004 Ports, in this order:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], stable from DECODE until the next FETCH
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst, Branch_Sel  out  1 each  datapath controls
- PCSource, ALUOp, ALUSrcB  out  2 each  datapath selects
- instr_done  out  1  one-cycle pulse when an instruction retires
- err  out  1  sticky fault flag
- state_o  out  4  current state encoding, for debug

Function
REQ-005 SHALL be a registered-state FSM; outputs SHALL decode from state, except IRWrite, PCWrite and instr_done, which may also depend on mem_ready as stated below; outputs not listed for a state SHALL be 0.
REQ-006 States and encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RTYPE_EX=7, RTYPE_WB=8, BR_EX=9, JUMP=10, ADDI_EX=11, ADDI_WB=12, ERROR=15.
REQ-007 IDLE: all outputs 0; SHALL go to FETCH on the next cycle.
REQ-008 FETCH: MemRead=1, ALUSrcB=01; IRWrite=PCWrite=mem_ready; SHALL go to DECODE when mem_ready=1, else hold.
REQ-009 DECODE: ALUSrcB=11.
- SHALL branch on opcode: 0 -> RTYPE_EX; 35 or 43 -> MEMADR; 4 (or 5 when BNE_EN=1) -> BR_EX; 2 -> JUMP; 8 -> ADDI_EX.
- Any other opcode -> ERROR.
REQ-010 MEMADR: ALUSrcA=1, ALUSrcB=10; SHALL go to MEMRD if opcode=35, else MEMWR.
REQ-011 MEMRD: MemRead=1, IorD=1; SHALL go to MEMWB when mem_ready=1.
REQ-012 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1; SHALL go to FETCH.
REQ-013 MEMWR: MemWrite=1, IorD=1; instr_done=mem_ready; SHALL go to FETCH when mem_ready=1.
REQ-014 RTYPE_EX: ALUSrcA=1, ALUOp=10; then RTYPE_WB. RTYPE_WB: RegDst=1, RegWrite=1, instr_done=1; then FETCH.
REQ-015 BR_EX: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01, Branch_Sel=(opcode==5), instr_done=1; then FETCH.
REQ-016 JUMP: PCWrite=1, PCSource=10, instr_done=1; then FETCH.
REQ-017 ADDI_EX: ALUSrcA=1, ALUSrcB=10; then ADDI_WB. ADDI_WB: RegWrite=1, RegDst=0, instr_done=1; then FETCH.
REQ-018 Wait counter:
- SHALL clear on entry to FETCH, MEMRD or MEMWR.
- SHALL increment each cycle in those states while mem_ready=0.
- Width SHALL be clog2(MEM_TIMEOUT+1).
REQ-019 When MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with mem_ready=0, SHALL go to ERROR next cycle.
- If mem_ready=1 in that same cycle, mem_ready wins and the access completes.
REQ-020 ERROR: all datapath outputs 0, err=1; SHALL hold until reset.
REQ-021 Per-instruction cycle counts with mem_ready tied high: R=4, LW=5, SW=4, BEQ/BNE=3, J=3, ADDI=4.

Reset
REQ-022 reset_n=0 SHALL asynchronously force state=IDLE, counter=0 and err=0; all outputs SHALL read 0 while reset is held.
REQ-023 Reset asserted mid-instruction SHALL abandon that instruction with no further write strobe; after release, the FSM SHALL restart at IDLE.

Structure
REQ-024 Opcode constants (0, 35, 43, 4, 5, 2, 8), state encodings and ALUOp/PCSource/ALUSrcB codes SHALL live in a shared package, mips_ctrl_pkg.
REQ-025 The wait/timeout counter SHALL be one sub-module, mem_wait_timer.

Verification
REQ-026 Bench SHALL cover these directed scenarios:
- Reset, then mem_ready=1 and opcode=35: states 0,1,2,3,4,5,1; RegWrite=MemtoReg=1 only in MEMWB; instr_done pulses once.
- opcode=5, BNE_EN=1: BR_EX has PCWriteCond=1, Branch_Sel=1, PCSource=01. With BNE_EN=0: DECODE -> ERROR and err=1.
- SW with mem_ready low 3 cycles in MEMWR: MemWrite held 4 cycles; instr_done only in the ready cycle.
- MEM_TIMEOUT=4, mem_ready stuck low in FETCH: ERROR after 5 FETCH cycles; err stays 1 until reset_n=0.
- opcode=63 -> ERROR. reset_n pulsed low during MEMRD: state_o=0 immediately, all outputs 0.
- Back-to-back R, ADDI, J with ready=1: 4+4+3 cycles; exactly three instr_done pulses.
